// File: rtl/id_scoreboard_stage.sv
// Instruction decode stage with a per-register pending-write counter scoreboard for RAW stalls.
// Optional ID_WB_BYPASS_EN lets a source whose last pending write retires this cycle issue using wb_data_i.
module id_decoder #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic [31:0]     instr,
  output logic [AW-1:0]   rd,
  output logic [AW-1:0]   rs1,
  output logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] imm,
  output logic            invalid
);
  always_comb begin
    invalid = 1'b0;
    rd      = instr[7 +: AW];
    rs1     = instr[15 +: AW];
    rs2     = instr[20 +: AW];
    imm     = '0;
    case (instr[6:0])
      7'b0110111, 7'b0010111: imm = XLEN'($signed({instr[31:12], 12'b0}));
      7'b1101111: imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011:
        imm = XLEN'($signed(instr[31:20]));
      7'b1100011: begin
        rd  = '0;
        imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      end
      7'b0100011: begin
        rd  = '0;
        imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      7'b0110011: imm = '0;
      default: begin
        invalid = 1'b1;
        rd      = '0;
      end
    endcase
  end
endmodule

module id_pend_ctr #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rstn_i,
  input  logic              inc,
  input  logic              wb_hit,
  input  logic              sq_rel,
  output logic [PEND_W-1:0] pend,
  output logic [PEND_W-1:0] pend_nxt
);
  logic [PEND_W+1:0] up, dec;

  // Decrements floor at zero; saturation is prevented by the issue check.
  always_comb begin
    dec = {{PEND_W{1'b0}}, 2'(wb_hit && pend != '0) + 2'(sq_rel)};
    up  = {2'b00, pend} + {{(PEND_W+1){1'b0}}, inc};
    pend_nxt = (up >= dec) ? PEND_W'(up - dec) : '0;
  end

  always_ff @(posedge clk or negedge rstn_i)
    if (!rstn_i) pend <= '0;
    else         pend <= pend_nxt;
endmodule

module id_scoreboard_stage #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int PEND_W = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rstn_i,
  input  logic            flush_i,
  output logic [AW-1:0]   rs1a_o,
  output logic [AW-1:0]   rs2a_o,
  input  logic [XLEN-1:0] rs1d_i,
  input  logic [XLEN-1:0] rs2d_i,
  input  logic            valid_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            ack_o,
  input  logic            ack_i,
  output logic            valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] rs1_o,
  output logic [XLEN-1:0] rs2_o,
  output logic [XLEN-1:0] imm_o,
  input  logic            wb_valid_i,
  input  logic [AW-1:0]   wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            illegal_o,
  output logic            busy_o
);
  localparam logic [PEND_W-1:0] PMAX = '1;

  logic [AW-1:0]     d_rd, d_rs1, d_rs2, rd_q;
  logic [XLEN-1:0]   d_imm, op1, op2;
  logic              d_inv, slot_free, issue, squash, rs1_ok, rs2_ok, rd_ok, busy_n;
  logic [PEND_W-1:0] pend     [NREGS];
  logic [PEND_W-1:0] pend_nxt [NREGS];

  id_decoder #(.XLEN(XLEN), .AW(AW)) u_dec (
    .instr(instr_i), .rd(d_rd), .rs1(d_rs1), .rs2(d_rs2), .imm(d_imm), .invalid(d_inv)
  );

  assign rs1a_o = d_rs1;
  assign rs2a_o = d_rs2;

  genvar r;
  generate
    for (r = 0; r < NREGS; r++) begin : g_ctr
      if (r == 0) begin : g_zero
        assign pend[r]     = '0;
        assign pend_nxt[r] = '0;
      end else begin : g_live
        id_pend_ctr #(.PEND_W(PEND_W)) u_ctr (
          .clk(clk), .rstn_i(rstn_i),
          .inc(issue && d_rd == AW'(r)),
          .wb_hit(wb_valid_i && wb_rd_i == AW'(r)),
          .sq_rel(squash && rd_q == AW'(r)),
          .pend(pend[r]), .pend_nxt(pend_nxt[r])
        );
      end
    end
  endgenerate

`ifdef ID_WB_BYPASS_EN
  logic byp1, byp2;
  always_comb begin
    byp1 = pend[d_rs1] == PEND_W'(1) && wb_valid_i && wb_rd_i == d_rs1 && d_rs1 != '0;
    byp2 = pend[d_rs2] == PEND_W'(1) && wb_valid_i && wb_rd_i == d_rs2 && d_rs2 != '0;
    rs1_ok = pend[d_rs1] == '0 || byp1;
    rs2_ok = pend[d_rs2] == '0 || byp2;
    op1 = byp1 ? wb_data_i : rs1d_i;
    op2 = byp2 ? wb_data_i : rs2d_i;
  end
`else
  logic unused_wb;
  assign unused_wb = ^wb_data_i;
  always_comb begin
    rs1_ok = pend[d_rs1] == '0;
    rs2_ok = pend[d_rs2] == '0;
    op1 = rs1d_i;
    op2 = rs2d_i;
  end
`endif

  always_comb begin
    slot_free = !valid_o || ack_i;
    rd_ok     = d_rd == '0 || pend[d_rd] != PMAX;
    issue     = slot_free && valid_i && !d_inv && !flush_i && rs1_ok && rs2_ok && rd_ok;
    squash    = flush_i && valid_o && !ack_i;
    busy_n    = 1'b0;
    for (int i = 0; i < NREGS; i++) busy_n = busy_n | (pend_nxt[i] != '0);
  end

  assign ack_o = issue;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_o   <= 1'b0;
      instr_o   <= '0;
      pc_o      <= '0;
      rs1_o     <= '0;
      rs2_o     <= '0;
      imm_o     <= '0;
      rd_q      <= '0;
      illegal_o <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      busy_o <= busy_n;
      if (flush_i)                             illegal_o <= 1'b0;
      else if (valid_i && d_inv && slot_free)  illegal_o <= 1'b1;
      if (flush_i) valid_o <= 1'b0;
      else if (issue) begin
        valid_o <= 1'b1;
        instr_o <= instr_i;
        pc_o    <= pc_i;
        rs1_o   <= op1;
        rs2_o   <= op2;
        imm_o   <= d_imm;
        rd_q    <= d_rd;
      end else if (ack_i) valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_id_scoreboard_stage.sv
// Directed bench for id_scoreboard_stage: hazards, saturation, flush, illegal, x0 and async reset.
module tb_id_scoreboard_stage;
  logic        clk = 1'b0, rstn_i = 1'b0, flush_i = 1'b0;
  logic [4:0]  rs1a_o, rs2a_o, wb_rd_i = '0;
  logic [31:0] rs1d_i = '0, rs2d_i = '0, instr_i = '0, pc_i = '0, wb_data_i = '0;
  logic        valid_i = 1'b0, ack_i = 1'b0, wb_valid_i = 1'b0;
  logic        ack_o, valid_o, illegal_o, busy_o;
  logic [31:0] instr_o, pc_o, rs1_o, rs2_o, imm_o;
  int n_cmp = 0, n_err = 0;

  id_scoreboard_stage dut (
    .clk(clk), .rstn_i(rstn_i), .flush_i(flush_i), .rs1a_o(rs1a_o), .rs2a_o(rs2a_o),
    .rs1d_i(rs1d_i), .rs2d_i(rs2d_i), .valid_i(valid_i), .instr_i(instr_i), .pc_i(pc_i),
    .ack_o(ack_o), .ack_i(ack_i), .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .imm_o(imm_o), .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
    .wb_data_i(wb_data_i), .illegal_o(illegal_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #12;
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_imm", imm_o, 32'h0);
    chk("rst_illegal", illegal_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ack", ack_o, 1'b0);
    rstn_i = 1'b1;
    tick();

    valid_i = 1'b1; instr_i = mk_i(5'd1, 5'd0, 12'd5); pc_i = 32'h100; rs1d_i = 32'h0; ack_i = 1'b1;
    #1 chk("addi_ack", ack_o, 1'b1);
    tick();
    chk("addi_valid", valid_o, 1'b1);
    chk("addi_imm", imm_o, 32'd5);
    chk("addi_pc", pc_o, 32'h100);
    chk("addi_instr", instr_o, 32'h00500093);
    chk("addi_pend1", dut.pend[1], 2'd1);
    chk("addi_busy", busy_o, 1'b1);

    instr_i = mk_r(5'd2, 5'd1, 5'd1); pc_i = 32'h104; rs1d_i = 32'h11; rs2d_i = 32'h22;
    #1 chk("raw_stall_ack", ack_o, 1'b0);
    tick();
    chk("raw_valid_drop", valid_o, 1'b0);
    chk("raw_pend1_held", dut.pend[1], 2'd1);
    wb_valid_i = 1'b1; wb_rd_i = 5'd1; wb_data_i = 32'h55;
`ifdef ID_WB_BYPASS_EN
    #1 chk("byp_ack", ack_o, 1'b1);
    tick();
    wb_valid_i = 1'b0; valid_i = 1'b0;
    chk("byp_valid", valid_o, 1'b1);
    chk("byp_rs1", rs1_o, 32'h55);
    chk("byp_rs2", rs2_o, 32'h55);
    chk("byp_pend1", dut.pend[1], 2'd0);
    chk("byp_pend2", dut.pend[2], 2'd1);
`else
    #1 chk("wb_cycle_ack", ack_o, 1'b0);
    tick();
    wb_valid_i = 1'b0;
    chk("wb_pend1", dut.pend[1], 2'd0);
    #1 chk("raw_issue_ack", ack_o, 1'b1);
    tick();
    valid_i = 1'b0;
    chk("raw_valid", valid_o, 1'b1);
    chk("raw_rs1", rs1_o, 32'h11);
    chk("raw_rs2", rs2_o, 32'h22);
    chk("raw_instr", instr_o, 32'h00108133);
    chk("raw_pend2", dut.pend[2], 2'd1);
`endif
    wb_valid_i = 1'b1; wb_rd_i = 5'd2;
    tick();
    wb_valid_i = 1'b0;
    chk("drain_pend2", dut.pend[2], 2'd0);
    chk("drain_busy", busy_o, 1'b0);
    chk("drain_valid", valid_o, 1'b0);

    valid_i = 1'b1; instr_i = mk_i(5'd3, 5'd0, 12'd1);
    for (int i = 0; i < 3; i++) begin
      #1 chk("sat_ack", ack_o, 1'b1);
      tick();
    end
    chk("sat_pend3", dut.pend[3], 2'd3);
    #1 chk("sat_stall", ack_o, 1'b0);
    tick();
    wb_valid_i = 1'b1; wb_rd_i = 5'd3;
    #1 chk("sat_wb_stall", ack_o, 1'b0);
    tick();
    chk("sat_pend3_dec", dut.pend[3], 2'd2);
    #1 chk("sat_inc_dec_ack", ack_o, 1'b1);
    tick();
    chk("sat_inc_dec_pend", dut.pend[3], 2'd2);
    wb_valid_i = 1'b0;
    #1 chk("sat_refill_ack", ack_o, 1'b1);
    tick();
    chk("sat_refill_pend", dut.pend[3], 2'd3);
    valid_i = 1'b0; wb_valid_i = 1'b1;
    repeat (3) tick();
    chk("sat_drained", dut.pend[3], 2'd0);
    tick();
    wb_valid_i = 1'b0;
    chk("floor_pend3", dut.pend[3], 2'd0);
    chk("floor_busy", busy_o, 1'b0);

    valid_i = 1'b1; instr_i = mk_i(5'd4, 5'd0, 12'd0); ack_i = 1'b1;
    tick();
    valid_i = 1'b0; ack_i = 1'b0;
    tick();
    chk("hold_valid", valid_o, 1'b1);
    chk("hold_pend4", dut.pend[4], 2'd1);
    flush_i = 1'b1; valid_i = 1'b1; instr_i = mk_i(5'd6, 5'd0, 12'd0);
    #1 chk("flush_ack", ack_o, 1'b0);
    tick();
    flush_i = 1'b0; valid_i = 1'b0;
    chk("flush_valid", valid_o, 1'b0);
    chk("flush_pend4", dut.pend[4], 2'd0);
    chk("flush_pend6", dut.pend[6], 2'd0);

    valid_i = 1'b1; instr_i = 32'hFFFF_FFFF;
    #1 chk("ill_ack", ack_o, 1'b0);
    tick();
    chk("ill_set", illegal_o, 1'b1);
    tick();
    chk("ill_hold", illegal_o, 1'b1);
    chk("ill_stall_ack", ack_o, 1'b0);
    valid_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("ill_clear", illegal_o, 1'b0);

    valid_i = 1'b1; instr_i = mk_i(5'd0, 5'd0, 12'd1); ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("x0_ack", ack_o, 1'b1);
      tick();
      chk("x0_pend0", dut.pend[0], 2'd0);
    end
    chk("x0_busy", busy_o, 1'b0);

    instr_i = mk_i(5'd5, 5'd0, 12'd0);
    tick();
    valid_i = 1'b0;
    chk("pre_rst_pend5", dut.pend[5], 2'd1);
    #2 rstn_i = 1'b0;
    #1;
    chk("arst_valid", valid_o, 1'b0);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_pend5", dut.pend[5], 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
